// File: rtl/decode_unit_pkg.sv
// Shared processor definitions: opcodes, ALU operation codes and the decoded-entry record
// carried through the decode output buffer.
package processor_defines;

  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;

  typedef enum logic [4:0] {
    ALU_NOP   = 5'd0,
    ALU_ADD   = 5'd1,
    ALU_SUB   = 5'd2,
    ALU_SLL   = 5'd3,
    ALU_SLT   = 5'd4,
    ALU_SLTU  = 5'd5,
    ALU_XOR   = 5'd6,
    ALU_SRL   = 5'd7,
    ALU_SRA   = 5'd8,
    ALU_OR    = 5'd9,
    ALU_AND   = 5'd10,
    ALU_ADDI  = 5'd11,
    ALU_SLTI  = 5'd12,
    ALU_SLTIU = 5'd13,
    ALU_XORI  = 5'd14,
    ALU_ORI   = 5'd15,
    ALU_ANDI  = 5'd16,
    ALU_SLLI  = 5'd17,
    ALU_SRLI  = 5'd18,
    ALU_SRAI  = 5'd19
  } alu_op_e;

  // imm is held at the widest legal XLEN; narrower datapaths use the low bits.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] imm;
    logic        use_imm;
    alu_op_e     alu_control;
    logic        illegal;
  } decode_entry_t;

endpackage

// File: rtl/decode_unit_if.sv
// Instruction-in / decoded-fields-out handshake bundle for decode_unit.
interface decode_unit_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              instruction_code;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [4:0]               rs1;
  logic [4:0]               rs2;
  logic [4:0]               rd;
  logic [XLEN-1:0]          imm;
  logic                     use_imm;
  logic [4:0]               alu_control;
  logic                     illegal;
  logic [$clog2(DEPTH):0]   count;

  modport master (
    output in_valid, instruction_code, flush, out_ready,
    input  in_ready, out_valid, rs1, rs2, rd, imm, use_imm, alu_control, illegal, count
  );

  modport slave (
    input  in_valid, instruction_code, flush, out_ready,
    output in_ready, out_valid, rs1, rs2, rd, imm, use_imm, alu_control, illegal, count
  );

endinterface

// File: rtl/decode_unit_fields.sv
// Combinational RV integer OP / OP-IMM decoder producing one buffer entry.
module decode_fields
  import processor_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]   instruction_code,
  output decode_entry_t entry
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       shift_logical;
  logic       shift_arith;
  logic       bad;

  assign opcode = instruction_code[6:0];
  assign funct3 = instruction_code[14:12];
  assign funct7 = instruction_code[31:25];

  // RV64 shift immediates carry a 6-bit shamt, so only imm[11:6] selects the shift kind.
  always_comb begin
    shift_logical = 1'b0;
    shift_arith   = 1'b0;
    if (XLEN == 64) begin
      shift_logical = (instruction_code[31:26] == 6'h00);
      shift_arith   = (instruction_code[31:26] == 6'h10);
    end else begin
      shift_logical = (instruction_code[31:25] == 7'h00);
      shift_arith   = (instruction_code[31:25] == 7'h20);
    end
  end

  always_comb begin
    entry             = '0;
    bad               = 1'b0;
    entry.rd          = instruction_code[11:7];
    entry.rs1         = instruction_code[19:15];
    entry.rs2         = instruction_code[24:20];
    entry.alu_control = ALU_NOP;
    case (opcode)
      OP_IMM: begin
        entry.imm     = {{52{instruction_code[31]}}, instruction_code[31:20]};
        entry.use_imm = 1'b1;
        case (funct3)
          3'b000:  entry.alu_control = ALU_ADDI;
          3'b010:  entry.alu_control = ALU_SLTI;
          3'b011:  entry.alu_control = ALU_SLTIU;
          3'b100:  entry.alu_control = ALU_XORI;
          3'b110:  entry.alu_control = ALU_ORI;
          3'b111:  entry.alu_control = ALU_ANDI;
          3'b001:  if (shift_logical) entry.alu_control = ALU_SLLI;
                   else bad = 1'b1;
          default: if (shift_logical) entry.alu_control = ALU_SRLI;
                   else if (shift_arith) entry.alu_control = ALU_SRAI;
                   else bad = 1'b1;
        endcase
      end
      OP: begin
        case ({funct7, funct3})
          {7'h00, 3'b000}: entry.alu_control = ALU_ADD;
          {7'h20, 3'b000}: entry.alu_control = ALU_SUB;
          {7'h00, 3'b001}: entry.alu_control = ALU_SLL;
          {7'h00, 3'b010}: entry.alu_control = ALU_SLT;
          {7'h00, 3'b011}: entry.alu_control = ALU_SLTU;
          {7'h00, 3'b100}: entry.alu_control = ALU_XOR;
          {7'h00, 3'b101}: entry.alu_control = ALU_SRL;
          {7'h20, 3'b101}: entry.alu_control = ALU_SRA;
          {7'h00, 3'b110}: entry.alu_control = ALU_OR;
          {7'h00, 3'b111}: entry.alu_control = ALU_AND;
          default:         bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      entry.illegal     = 1'b1;
      entry.use_imm     = 1'b0;
      entry.alu_control = ALU_NOP;
    end
  end

endmodule

// File: rtl/decode_unit.sv
// Decode stage: combinational decode feeding a DEPTH-entry circular output buffer.
module decode_unit
  import processor_defines::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic          clk,
  input logic          reset,
  decode_unit_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decode_entry_t dec_p0;
  decode_entry_t buf_p1 [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;

  decode_fields #(.XLEN(XLEN)) u_fields (
    .instruction_code (bus.instruction_code),
    .entry            (dec_p0)
  );

  assign bus.in_ready  = (cnt != CW'(DEPTH));
  assign bus.out_valid = (cnt != '0);
  assign bus.count     = cnt;
  assign push          = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop           = bus.out_valid && bus.out_ready && !bus.flush;

  // ---- stage p0 -> p1: buffer write; pointers wrap naturally at PW bits ----
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_p1[wptr] <= dec_p0;
  end

  // ---- stage p1 output: head entry, forced to zero when the buffer is empty ----
  always_comb begin
    bus.rs1         = '0;
    bus.rs2         = '0;
    bus.rd          = '0;
    bus.imm         = '0;
    bus.use_imm     = 1'b0;
    bus.alu_control = '0;
    bus.illegal     = 1'b0;
    if (bus.out_valid) begin
      bus.rs1         = buf_p1[rptr].rs1;
      bus.rs2         = buf_p1[rptr].rs2;
      bus.rd          = buf_p1[rptr].rd;
      bus.imm         = buf_p1[rptr].imm[XLEN-1:0];
      bus.use_imm     = buf_p1[rptr].use_imm;
      bus.alu_control = buf_p1[rptr].alu_control;
      bus.illegal     = buf_p1[rptr].illegal;
    end
  end

endmodule
